// File: rtl/fetch_queue.sv
// fetch_queue: fetches cache lines into a circular byte buffer and presents
// a decode window starting at the head byte.
// Optional feature macro: FETCH_QUEUE_PERF_EN adds the perf_starve counter.
// Byte order: the lowest-address byte of a response beat and of the window
// sits in the most significant byte lane.
module fetch_queue #(
  parameter int BUF_BYTES  = 128,
  parameter int LINE_BYTES = 64,
  parameter int BEAT_BYTES = 8,
  parameter int WIN_BYTES  = 15
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [63:0]                    entry,
  output logic                           req_valid,
  output logic [63:0]                    req_addr,
  input  logic                           req_ack,
  input  logic                           resp_valid,
  input  logic [BEAT_BYTES*8-1:0]        resp_data,
  output logic                           resp_ack,
  output logic [WIN_BYTES*8-1:0]         win_data,
  output logic                           win_valid,
  input  logic [$clog2(WIN_BYTES+1)-1:0] consume,
  input  logic                           redirect,
  input  logic [63:0]                    redirect_addr,
  output logic [$clog2(BUF_BYTES):0]     avail,
  output logic                           err_underflow
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]                    perf_starve
`endif
);

  localparam int PTR_W  = $clog2(BUF_BYTES);
  localparam int AV_W   = PTR_W + 1;
  localparam int LOFF_W = $clog2(LINE_BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, ACTIVE, DRAIN} state_t;

  state_t             state;
  state_t             state_next;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [63:0]        fetch_addr;
  logic [LOFF_W-1:0]  skip;
  logic               stale;
  logic               drain_seen;
  logic [7:0]         mem [BUF_BYTES];

  logic               beat_live;
  logic               beat_write;
  logic               beat_skip;
  logic [AV_W-1:0]    consume_ext;
  logic               underflow;
  logic [AV_W-1:0]    consumed;
  logic [AV_W-1:0]    fill;
  logic               can_request;

  assign resp_ack  = resp_valid;
  assign win_valid = (avail >= AV_W'(WIN_BYTES));

  // Beats only count while a line we asked for is in flight; stale beats left
  // over from a reset, and any beat in a redirect cycle, are thrown away.
  assign beat_live  = resp_valid && !redirect && !stale &&
                      ((state == WAIT) || (state == ACTIVE));
  assign beat_write = beat_live && (skip == '0);
  assign beat_skip  = beat_live && (skip != '0);

  // Consumption is clamped to what is actually buffered; a redirect cycle
  // ignores consume altogether since the buffer is being flushed.
  assign consume_ext = AV_W'(consume);
  assign underflow   = !redirect && (consume_ext > avail);
  assign consumed    = redirect ? '0 : (underflow ? avail : consume_ext);
  assign fill        = beat_write ? AV_W'(BEAT_BYTES) : '0;

  // A new line is requested only from IDLE when a whole line fits.
  assign can_request = (state == IDLE) && !req_ack && !redirect && !stale &&
                       (avail <= AV_W'(BUF_BYTES - LINE_BYTES));

  // Next-state logic for the line fetch sequencer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        // An acknowledged request together with a redirect still has a line
        // on its way back, so it must be drained rather than forgotten.
        if (req_ack) state_next = redirect ? DRAIN : WAIT;
      end
      WAIT: begin
        if (redirect)        state_next = DRAIN;
        else if (resp_valid) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (redirect)         state_next = DRAIN;
        else if (!resp_valid) state_next = IDLE;
      end
      DRAIN: begin
        if (!resp_valid && drain_seen) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state, buffer pointers, occupancy, fetch address and flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      req_valid     <= 1'b0;
      req_addr      <= '0;
      head          <= '0;
      tail          <= '0;
      avail         <= '0;
      err_underflow <= 1'b0;
      fetch_addr    <= entry & ~64'(BEAT_BYTES - 1);
      skip          <= entry[LOFF_W-1:0] & ~LOFF_W'(BEAT_BYTES - 1);
      stale         <= 1'b1;
      drain_seen    <= 1'b0;
    end else begin
      state     <= state_next;
      req_valid <= can_request;
      if (can_request) req_addr <= fetch_addr & ~64'(LINE_BYTES - 1);
      if (!resp_valid) stale <= 1'b0;
      if (state == DRAIN) drain_seen <= drain_seen | resp_valid;
      else                drain_seen <= (state == ACTIVE) | resp_valid;
      if (redirect) begin
        head       <= '0;
        tail       <= '0;
        avail      <= '0;
        fetch_addr <= redirect_addr & ~64'(BEAT_BYTES - 1);
        skip       <= redirect_addr[LOFF_W-1:0] & ~LOFF_W'(BEAT_BYTES - 1);
      end else begin
        head  <= head + PTR_W'(consumed);
        avail <= avail + fill - consumed;
        if (beat_write) begin
          tail       <= tail + PTR_W'(BEAT_BYTES);
          fetch_addr <= fetch_addr + 64'(BEAT_BYTES);
        end
        if (beat_skip) skip <= skip - LOFF_W'(BEAT_BYTES);
        if (underflow) err_underflow <= 1'b1;
      end
    end
  end

  // Byte storage; the tail stays beat aligned so a beat never straddles the end.
  always_ff @(posedge clk) begin
    if (beat_write) begin
      for (int i = 0; i < BEAT_BYTES; i++) begin
        mem[tail + PTR_W'(i)] <= resp_data[(BEAT_BYTES-1-i)*8 +: 8];
      end
    end
  end

  // Decode window gathered from the head, wrapping across the buffer end.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < WIN_BYTES; i++) begin
      win_data[(WIN_BYTES-1-i)*8 +: 8] = mem[head + PTR_W'(i)];
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  // Saturating count of cycles where the decoder is starved of bytes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_starve <= '0;
    end else if (!win_valid && !redirect && (perf_starve != '1)) begin
      perf_starve <= perf_starve + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter BUF_BYTES, 128, circular byte-buffer capacity; power of 2, at least 2*LINE_BYTES.
REQ-002 SHALL have parameter LINE_BYTES, 64, bytes per bus read request; power of 2.
REQ-003 SHALL have parameter BEAT_BYTES, 8, bytes per response beat; divides LINE_BYTES.
REQ-004 SHALL have parameter WIN_BYTES, 15, decode-window width in bytes; at most LINE_BYTES.
REQ-005 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port entry  input  64  start byte address, sampled while reset is low.
REQ-008 SHALL have ports req_valid  output  1, req_addr  output  64, and req_ack  input  1: line read request.
REQ-009 SHALL have ports resp_valid  input  1, resp_data  input  BEAT_BYTES*8, and resp_ack  output  1: response beats.
REQ-010 SHALL have port win_data  output  WIN_BYTES*8  bytes from head; byte 0 is at the MSBs, in increasing address order.
REQ-011 SHALL have port win_valid  output  1  high when avail >= WIN_BYTES.
REQ-012 SHALL have port consume  input  clog2(WIN_BYTES+1)  bytes retired by the decoder this cycle.
REQ-013 SHALL have ports redirect  input  1 and redirect_addr  input  64: flush and refetch from a new address.
REQ-014 SHALL have port avail  output  clog2(BUF_BYTES)+1  count of valid bytes.
REQ-015 SHALL have port err_underflow  output  1  sticky flag, set when consume > avail.

Function
REQ-016 SHALL run an FSM with states IDLE, WAIT, ACTIVE and DRAIN.
REQ-017 SHALL move IDLE->WAIT on req_ack, WAIT->ACTIVE on the first resp_valid, and ACTIVE->IDLE on the first cycle with no resp_valid.
REQ-018 SHALL assert req_valid registered, only in IDLE, with req_ack low, redirect low, and free space (BUF_BYTES-avail) >= LINE_BYTES.
REQ-019 SHALL set req_addr to fetch_addr with the low log2(LINE_BYTES) bits cleared.
REQ-020 SHALL drive resp_ack equal to resp_valid combinationally.
REQ-021 SHALL, per accepted beat, write the beat at the tail with wrap-around modulo BUF_BYTES, advance the tail by BEAT_BYTES, and advance fetch_addr by BEAT_BYTES.
REQ-022 SHALL, while the skip count is nonzero, discard each beat without writing it and reduce skip by BEAT_BYTES.
REQ-023 SHALL, while win_valid is high, advance the head by consume modulo BUF_BYTES.
REQ-024 SHALL update avail as avail + filled - consumed; a simultaneous fill and consume SHALL be exact.
REQ-025 SHALL, when consume > avail, consume only avail bytes and set err_underflow until reset.
REQ-026 SHALL build win_data from bytes that wrap across the buffer end in address order; win_data is don't-care when win_valid is low.
REQ-027 SHALL treat redirect as highest priority: the next edge sets head=tail=avail=0, fetch_addr=redirect_addr aligned to BEAT_BYTES, and skip=redirect_addr[log2(LINE_BYTES)-1:0] aligned down to BEAT_BYTES.
REQ-028 SHALL, on a redirect in WAIT or ACTIVE, enter DRAIN, discard all remaining beats of the old line, and go DRAIN->IDLE on the first cycle with no resp_valid after a beat.
REQ-029 SHALL, on a redirect in IDLE, stay in IDLE and ignore the same-cycle consume.
REQ-030 SHALL issue no new request during DRAIN.
REQ-031 SHALL ignore a redirect arriving while in DRAIN except to reload fetch_addr and skip.

Reset
REQ-032 SHALL, while reset is low, hold state=IDLE, req_valid=0, req_addr=0, head=tail=avail=0, and err_underflow=0.
REQ-033 SHALL, while reset is low, load fetch_addr from entry and skip from entry low bits, per REQ-027 rules.
REQ-034 SHALL, when reset asserts mid-line, abandon the line; beats arriving after release SHALL be acked and discarded until the first idle cycle.

Configuration
REQ-035 SHALL support macro FETCH_QUEUE_PERF_EN; when defined, add output perf_starve  32 bits, counting cycles with win_valid low and no redirect, reset to 0 and saturating at 2^32-1.
REQ-036 SHALL, when FETCH_QUEUE_PERF_EN is undefined, omit the port and its counter, with all other behaviour identical.

Verification
REQ-037 SHALL test entry=0x1000 with one line returned -> req_addr=0x1000, avail=64 after 8 beats, and win_data byte 0 = the first beat's first byte.
REQ-038 SHALL test entry=0x1013 -> req_addr=0x1000, two beats discarded, avail=48, and the head byte is the one at address 0x1010.
REQ-039 SHALL test consume=15 every cycle with continuous refills over 10 lines -> head wraps past 128 with no byte lost or duplicated, and req_valid is never raised when free space < 64.
REQ-040 SHALL test redirect to 0x2008 during beat 3 of a line -> state DRAIN, the remaining 5 beats discarded, then req_addr=0x2000 with one beat skipped.
REQ-041 SHALL test consume=9 with avail=4 -> avail=0 and err_underflow=1 held until reset.
REQ-042 SHALL test reset asserted mid-line -> all outputs at reset values immediately, and stale beats after release acked with avail unchanged.
